// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into instr[31:7] for I/S/B/shift/J/lui,
// range-checks it and counts illegal results. Two-stage valid/ready pipeline.
module imm_encoder #(
    parameter int unsigned ERR_CNT_W   = 8,
    parameter int unsigned CHECK_RANGE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_imm_type,
    input  logic [31:0]          i_imm,
    input  logic [24:0]          i_fields,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [24:0]          o_data,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int unsigned DATA_W = 25;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned KEEP_W = 21;

    localparam logic [TYPE_W-1:0] T_I     = 3'd0;
    localparam logic [TYPE_W-1:0] T_S     = 3'd1;
    localparam logic [TYPE_W-1:0] T_B     = 3'd2;
    localparam logic [TYPE_W-1:0] T_SHIFT = 3'd3;
    localparam logic [TYPE_W-1:0] T_J     = 3'd4;
    localparam logic [TYPE_W-1:0] T_LUI   = 3'd5;

    // Stage 1 state
    logic                 r_s1_v;
    logic [TYPE_W-1:0]    r_s1_type;
    logic [KEEP_W-1:0]    r_s1_imm;
    logic [DATA_W-1:0]    r_s1_fields;
    logic                 r_s1_ok;

    // Stage 2 state
    logic                 r_s2_v;
    logic [DATA_W-1:0]    r_data;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_s2_adv;
    logic                 w_s1_load;
    logic                 w_fits12;
    logic                 w_fits13;
    logic                 w_fits20;
    logic                 w_fits21;
    logic                 w_type_ok;
    logic                 w_range_ok;
    logic                 w_ok;
    logic [DATA_W-1:0]    w_mask;
    logic [DATA_W-1:0]    w_imm_bits;
    logic [DATA_W-1:0]    w_packed;

    assign w_s2_adv  = r_s1_v & (~r_s2_v | i_ready);
    assign o_ready   = ~r_s1_v | w_s2_adv;
    assign w_s1_load = i_valid & o_ready;

    // A value fits an N-bit signed field when all bits from N-1 upward agree.
    assign w_fits12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fits13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_fits20 = (&i_imm[31:19]) | ~(|i_imm[31:19]);
    assign w_fits21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);
    assign w_type_ok = (i_imm_type <= T_LUI);

    always_comb begin
        w_range_ok = 1'b0;
        case (i_imm_type)
            T_I, T_S: w_range_ok = w_fits12;
            T_B:      w_range_ok = w_fits13 & ~i_imm[0];
            T_SHIFT:  w_range_ok = ~(|i_imm[31:5]);
            T_J:      w_range_ok = w_fits21 & ~i_imm[0];
            T_LUI:    w_range_ok = w_fits20;
            default:  w_range_ok = 1'b0;
        endcase
    end

    // With the range check disabled only the type check can reject a request.
    assign w_ok = w_type_ok & ((CHECK_RANGE == 0) | w_range_ok);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_v      <= 1'b0;
            r_s1_type   <= '0;
            r_s1_imm    <= '0;
            r_s1_fields <= '0;
            r_s1_ok     <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_v      <= 1'b1;
            r_s1_type   <= i_imm_type;
            r_s1_imm    <= i_imm[KEEP_W-1:0];
            r_s1_fields <= i_fields;
            r_s1_ok     <= w_ok;
        end else if (w_s2_adv) begin
            r_s1_v      <= 1'b0;
        end
    end

    // Immediate bit positions per type and the scattered immediate bits.
    always_comb begin
        w_mask     = '0;
        w_imm_bits = '0;
        case (r_s1_type)
            T_I: begin
                w_mask[24:13]     = '1;
                w_imm_bits[24:13] = r_s1_imm[11:0];
            end
            T_S: begin
                w_mask[24:18]     = '1;
                w_mask[4:0]       = '1;
                w_imm_bits[24:18] = r_s1_imm[11:5];
                w_imm_bits[4:0]   = r_s1_imm[4:0];
            end
            T_B: begin
                w_mask[24:18]     = '1;
                w_mask[4:0]       = '1;
                w_imm_bits[24]    = r_s1_imm[12];
                w_imm_bits[23:18] = r_s1_imm[10:5];
                w_imm_bits[4:1]   = r_s1_imm[4:1];
                w_imm_bits[0]     = r_s1_imm[11];
            end
            T_SHIFT: begin
                w_mask[17:13]     = '1;
                w_imm_bits[17:13] = r_s1_imm[4:0];
            end
            T_J: begin
                w_mask[24:5]      = '1;
                w_imm_bits[24]    = r_s1_imm[20];
                w_imm_bits[23:14] = r_s1_imm[10:1];
                w_imm_bits[13]    = r_s1_imm[11];
                w_imm_bits[12:5]  = r_s1_imm[19:12];
            end
            T_LUI: begin
                w_mask[24:5]      = '1;
                w_imm_bits[24:5]  = r_s1_imm[19:0];
            end
            default: begin
                w_mask     = '0;
                w_imm_bits = '0;
            end
        endcase
    end

    assign w_packed = (r_s1_fields & ~w_mask) | (r_s1_ok ? w_imm_bits : DATA_W'(0));

    // Stage 2 holds its payload until the consumer takes it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s2_v <= 1'b0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v <= 1'b1;
            r_data <= w_packed;
            r_err  <= ~r_s1_ok;
        end else if (i_ready) begin
            r_s2_v <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (r_s2_v & i_ready & r_err & ~(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign o_valid   = r_s2_v;
    assign o_data    = r_data;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;

endmodule
